// File: rtl/serdes_lane_checker_if.sv
// rtl/serdes_lane_checker_if.sv - SERDES parallel-port bundle (tx_data to OSERDES, rx_data from ISERDES, bitslip)
interface serdes_lane_checker_if #(
    parameter int NUM_LANES  = 1,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_LANES*DATA_WIDTH-1:0] tx_data;  // lane n at [n*DATA_WIDTH +: DATA_WIDTH], bit 0 serialised first
    logic [NUM_LANES*DATA_WIDTH-1:0] rx_data;  // same packing as tx_data
    logic [NUM_LANES-1:0]            bitslip;  // one-cycle pulse per lane

    modport master (output tx_data, output bitslip, input rx_data);
    modport slave  (input tx_data, input bitslip, output rx_data);
endinterface

// File: rtl/serdes_lane_checker.sv
// rtl/serdes_lane_checker.sv - multi-lane SERDES word aligner and PRBS-7 bit-error checker; optional SERDES_LANE_CHECKER_INJECT_EN adds inject_err
module serdes_lane_checker #(
    parameter int         NUM_LANES     = 1,
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] TRAIN_WORD    = 8'h17,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SLIP_WAIT     = 4,
    parameter int         ERR_CNT_WIDTH = 16
) (
    input  logic                               clk,         // CLKDIV domain
    input  logic                               rst,         // async, active-high
    input  logic                               start,       // one-cycle pulse, restarts all lanes
`ifdef SERDES_LANE_CHECKER_INJECT_EN
    input  logic                               inject_err,  // flips tx bit 0 of lane 0 for one CHECK word
`endif
    serdes_lane_checker_if.master              sif,         // tx_data / rx_data / bitslip
    output logic [NUM_LANES-1:0]               lane_locked, // lane in CHECK
    output logic [NUM_LANES-1:0]               lane_fail,   // alignment gave up
    output logic [NUM_LANES*ERR_CNT_WIDTH-1:0] err_cnt,     // saturating bit-error count per lane
    output logic                               busy         // any lane in WAIT/TRAIN/SLIP
);
    localparam logic [DATA_WIDTH-1:0] TRAIN_W = TRAIN_WORD[DATA_WIDTH-1:0];
    localparam int WAIT_W     = $clog2(SLIP_WAIT + 1);
    localparam int MATCH_W    = $clog2(MATCH_COUNT + 1);
    localparam int SLIP_W     = $clog2(DATA_WIDTH + 1);
    localparam int POP_W      = $clog2(DATA_WIDTH + 1);
    // Words whose prediction still leans on pre-CHECK history.
    localparam int SKIP_WORDS = (7 + DATA_WIDTH - 1) / DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_TRAIN, ST_SLIP, ST_CHECK, ST_FAIL
    } state_t;

    logic                 inj_pulse;
    logic [NUM_LANES-1:0] training;

`ifdef SERDES_LANE_CHECKER_INJECT_EN
    assign inj_pulse = inject_err;
`else
    assign inj_pulse = 1'b0;
`endif

    assign busy = |training;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam bit IS_LANE0 = (l == 0);

        state_t                   state_q, state_d;
        logic [WAIT_W-1:0]        wait_q, wait_d;
        logic [MATCH_W-1:0]       match_q, match_d;
        logic [SLIP_W-1:0]        slip_q, slip_d;
        logic [2:0]               skip_q, skip_d;
        logic [6:0]               prbs_q, prbs_d;
        logic [6:0]               hist_q, hist_d;
        logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
        logic [DATA_WIDTH-1:0]    tx_q, tx_d;
        logic                     bitslip_q, bitslip_d;

        logic [DATA_WIDTH-1:0]    rx_word, prbs_word, chk_word;
        logic [6:0]               prbs_next;
        logic [POP_W-1:0]         pop;
        logic [ERR_CNT_WIDTH:0]   err_sum;

        assign rx_word = sif.rx_data[l*DATA_WIDTH +: DATA_WIDTH];

        // Both 7-bit histories keep bit 0 as the oldest bit (s[n-7]); each new
        // bit shifts in at the top, so s[n-7]^s[n-6] is always h[0]^h[1].
        always_comb begin : p_prbs_chk
            logic [6:0] g;
            logic [6:0] h;
            g         = prbs_q;
            h         = hist_q;
            prbs_word = '0;
            chk_word  = '0;
            pop       = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                prbs_word[i] = g[0] ^ g[1];
                g            = {prbs_word[i], g[6:1]};
                chk_word[i]  = h[0] ^ h[1] ^ rx_word[i];
                h            = {rx_word[i], h[6:1]};
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                pop = pop + POP_W'(chk_word[i]);
            end
            prbs_next = g;
            hist_d    = h;
        end

        assign err_sum = {1'b0, err_q} + (ERR_CNT_WIDTH + 1)'(pop);

        always_comb begin
            state_d = state_q;
            wait_d  = wait_q;
            match_d = match_q;
            slip_d  = slip_q;
            skip_d  = skip_q;
            err_d   = err_q;
            prbs_d  = prbs_q;

            case (state_q)
                ST_WAIT: begin
                    if (wait_q == WAIT_W'(SLIP_WAIT - 1)) state_d = ST_TRAIN;
                    else                                  wait_d  = wait_q + WAIT_W'(1);
                end
                ST_TRAIN: begin
                    if (rx_word == TRAIN_W) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_d = ST_CHECK;
                            skip_d  = 3'(SKIP_WORDS);
                        end
                    end else begin
                        match_d = '0;
                        state_d = (slip_q < SLIP_W'(DATA_WIDTH)) ? ST_SLIP : ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    slip_d  = slip_q + SLIP_W'(1);
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
                ST_CHECK: begin
                    if (skip_q != 3'd0)             skip_d = skip_q - 3'd1;
                    else if (err_sum[ERR_CNT_WIDTH]) err_d  = '1;
                    else                             err_d  = err_sum[ERR_CNT_WIDTH-1:0];
                end
                default: ;
            endcase

            if (start) begin
                state_d = ST_WAIT;
                wait_d  = '0;
                match_d = '0;
                slip_d  = '0;
                skip_d  = '0;
                err_d   = '0;
                prbs_d  = 7'h7F;
            end

            // tx is registered from the state being entered, giving the
            // one-cycle start -> TRAIN_WORD latency.
            tx_d = TRAIN_W;
            if (state_d == ST_IDLE) begin
                tx_d = '0;
            end else if (state_d == ST_CHECK) begin
                tx_d   = prbs_word;
                prbs_d = prbs_next;
                if (IS_LANE0 && inj_pulse && state_q == ST_CHECK) tx_d[0] = ~prbs_word[0];
            end
            bitslip_d = (state_d == ST_SLIP);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                wait_q    <= '0;
                match_q   <= '0;
                slip_q    <= '0;
                skip_q    <= '0;
                prbs_q    <= 7'h7F;
                hist_q    <= '0;
                err_q     <= '0;
                tx_q      <= '0;
                bitslip_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                wait_q    <= wait_d;
                match_q   <= match_d;
                slip_q    <= slip_d;
                skip_q    <= skip_d;
                prbs_q    <= prbs_d;
                hist_q    <= hist_d;
                err_q     <= err_d;
                tx_q      <= tx_d;
                bitslip_q <= bitslip_d;
            end
        end

        assign sif.tx_data[l*DATA_WIDTH +: DATA_WIDTH]   = tx_q;
        assign sif.bitslip[l]                            = bitslip_q;
        assign lane_locked[l]                            = (state_q == ST_CHECK);
        assign lane_fail[l]                              = (state_q == ST_FAIL);
        assign err_cnt[l*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_q;
        assign training[l] = (state_q == ST_WAIT) || (state_q == ST_TRAIN) || (state_q == ST_SLIP);
    end
endmodule

// File: tb/tb_serdes_lane_checker.sv
// tb/tb_serdes_lane_checker.sv - directed self-checking bench for serdes_lane_checker
module tb_serdes_lane_checker;
    localparam int NL = 4;
    localparam int W  = 8;
    localparam int EW = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
`ifdef SERDES_LANE_CHECKER_INJECT_EN
    logic inject_err = 1'b0;
`endif
    logic [NL-1:0]    lane_locked;
    logic [NL-1:0]    lane_fail;
    logic [NL*EW-1:0] err_cnt;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    serdes_lane_checker_if #(.NUM_LANES(NL), .DATA_WIDTH(W)) sif ();

    serdes_lane_checker #(
        .NUM_LANES(NL), .DATA_WIDTH(W), .TRAIN_WORD(8'h17),
        .MATCH_COUNT(16), .SLIP_WAIT(4), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef SERDES_LANE_CHECKER_INJECT_EN
        .inject_err(inject_err),
`endif
        .sif(sif),
        .lane_locked(lane_locked),
        .lane_fail(lane_fail),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Loopback: tx delayed 2 words, bit phase set per lane, each bitslip advances phase by one.
    logic [NL*W-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic            alt = 1'b0;
    int              slips [NL];
    int              p_base [NL];
    int              rx_mode = 0;  // 0 loopback, 1 all zero, 2 lane0 alternating 55/AA
    logic [W-1:0]    flip0 = '0;
    logic [NL*W-1:0] rx_model;

    always @(posedge clk) begin
        d1  <= sif.tx_data;
        d2  <= d1;
        d3  <= d2;
        alt <= ~alt;
        for (int l = 0; l < NL; l++)
            if (sif.bitslip[l]) slips[l] <= slips[l] + 1;
    end

    always_comb begin
        logic [2*W-1:0] pair;
        logic [W-1:0]   word;
        int             ph;
        rx_model = '0;
        pair     = '0;
        word     = '0;
        ph       = 0;
        for (int l = 0; l < NL; l++) begin
            ph   = (p_base[l] + slips[l]) % W;
            pair = {d2[l*W +: W], d3[l*W +: W]};
            word = pair[W-ph +: W];
            if (rx_mode == 1) word = '0;
            else if (rx_mode == 2 && l == 0) word = alt ? 8'h55 : 8'hAA;
            if (l == 0) word = word ^ flip0;
            rx_model[l*W +: W] = word;
        end
    end

    assign sif.rx_data = rx_model;

    task automatic set_phase(input int l, input int need);
        p_base[l] = ((W - need) - (slips[l] % W) + 2 * W) % W;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (sif.tx_data !== '0) begin n_errors++; $display("FAIL reset_tx: got %h want 0", sif.tx_data); end
        n_checks++; if (sif.bitslip !== '0) begin n_errors++; $display("FAIL reset_bitslip: got %b want 0", sif.bitslip); end
        n_checks++; if (lane_locked !== '0) begin n_errors++; $display("FAIL reset_locked: got %b want 0", lane_locked); end
        n_checks++; if (lane_fail !== '0) begin n_errors++; $display("FAIL reset_fail: got %b want 0", lane_fail); end
        n_checks++; if (err_cnt !== '0) begin n_errors++; $display("FAIL reset_err: got %h want 0", err_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_lock_lane0();
        int s0 [NL];
        int cyc;
        logic [NL*EW-1:0] base;
        set_phase(0, 3);
        for (int l = 1; l < NL; l++) set_phase(l, 0);
        for (int l = 0; l < NL; l++) s0[l] = slips[l];
        pulse_start();
        n_checks++; if (sif.tx_data[W-1:0] !== 8'h17) begin n_errors++; $display("FAIL start_latency_tx: got %h want 17", sif.tx_data[W-1:0]); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL start_busy: got %b want 1", busy); end
        cyc = 0;
        while (lane_locked !== 4'hF && cyc < 300) begin @(negedge clk); cyc++; end
        n_checks++; if (lane_locked !== 4'hF) begin n_errors++; $display("FAIL lock_timeout: got %b want 1111", lane_locked); end
        n_checks++; if (slips[0] - s0[0] !== 3) begin n_errors++; $display("FAIL lane0_slips: got %0d want 3", slips[0] - s0[0]); end
        n_checks++; if (lane_fail !== 4'h0) begin n_errors++; $display("FAIL lock_fail_flag: got %b want 0", lane_fail); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL lock_busy: got %b want 0", busy); end
        wait_cycles(4);
        base = err_cnt;
        wait_cycles(1000);
        n_checks++; if (err_cnt !== base) begin n_errors++; $display("FAIL prbs_clean: got %h want %h", err_cnt, base); end
        n_checks++; if (lane_locked !== 4'hF) begin n_errors++; $display("FAIL prbs_lock_held: got %b want 1111", lane_locked); end
    endtask

    task automatic test_rx_flip();
        logic [EW-1:0] base;
        base = err_cnt[EW-1:0];
        @(negedge clk) flip0 = 8'h08;
        @(negedge clk) flip0 = '0;
        wait_cycles(3);
        n_checks++; if (err_cnt[EW-1:0] !== base + 8'd3) begin n_errors++; $display("FAIL flip_err: got %0d want %0d", err_cnt[EW-1:0], base + 8'd3); end
        n_checks++; if (lane_locked[0] !== 1'b1) begin n_errors++; $display("FAIL flip_lock: got %b want 1", lane_locked[0]); end
    endtask

    task automatic test_saturate();
        rx_mode = 2;
        wait_cycles(200);
        n_checks++; if (err_cnt[EW-1:0] !== 8'hFF) begin n_errors++; $display("FAIL sat_err: got %0d want 255", err_cnt[EW-1:0]); end
        wait_cycles(10);
        n_checks++; if (err_cnt[EW-1:0] !== 8'hFF) begin n_errors++; $display("FAIL sat_hold: got %0d want 255", err_cnt[EW-1:0]); end
        n_checks++; if (lane_locked[0] !== 1'b1) begin n_errors++; $display("FAIL sat_lock: got %b want 1", lane_locked[0]); end
        rx_mode = 0;
    endtask

    task automatic test_reset_mid_check();
        int cyc;
        @(negedge clk) rst = 1'b1;
        #1;
        n_checks++; if (sif.tx_data !== '0) begin n_errors++; $display("FAIL rst_mid_tx: got %h want 0", sif.tx_data); end
        n_checks++; if (lane_locked !== '0) begin n_errors++; $display("FAIL rst_mid_locked: got %b want 0", lane_locked); end
        n_checks++; if (err_cnt !== '0) begin n_errors++; $display("FAIL rst_mid_err: got %h want 0", err_cnt); end
        n_checks++; if ({busy, lane_fail, sif.bitslip} !== '0) begin n_errors++; $display("FAIL rst_mid_misc: got %b want 0", {busy, lane_fail, sif.bitslip}); end
        @(negedge clk) rst = 1'b0;
        for (int l = 0; l < NL; l++) set_phase(l, 0);
        pulse_start();
        cyc = 0;
        while (lane_locked !== 4'hF && cyc < 300) begin @(negedge clk); cyc++; end
        n_checks++; if (lane_locked !== 4'hF) begin n_errors++; $display("FAIL relock: got %b want 1111", lane_locked); end
    endtask

    task automatic test_multi_lane();
        int s0 [NL];
        int cyc;
        logic [NL*EW-1:0] base;
        for (int l = 0; l < NL; l++) begin set_phase(l, l); s0[l] = slips[l]; end
        pulse_start();
        cyc = 0;
        while (lane_locked !== 4'hF && cyc < 300) begin @(negedge clk); cyc++; end
        n_checks++; if (lane_locked !== 4'hF) begin n_errors++; $display("FAIL multi_lock: got %b want 1111", lane_locked); end
        for (int l = 0; l < NL; l++) begin
            n_checks++; if (slips[l] - s0[l] !== l) begin n_errors++; $display("FAIL multi_slips lane %0d: got %0d want %0d", l, slips[l] - s0[l], l); end
        end
        wait_cycles(4);
        base = err_cnt;
        wait_cycles(200);
        n_checks++; if (err_cnt !== base) begin n_errors++; $display("FAIL multi_clean: got %h want %h", err_cnt, base); end
    endtask

`ifdef SERDES_LANE_CHECKER_INJECT_EN
    task automatic test_inject();
        logic [NL*EW-1:0] base;
        logic [NL*EW-1:0] want;
        base = err_cnt;
        want = base;
        want[EW-1:0] = base[EW-1:0] + 8'd3;
        @(negedge clk) inject_err = 1'b1;
        @(negedge clk) inject_err = 1'b0;
        wait_cycles(6);
        n_checks++; if (err_cnt !== want) begin n_errors++; $display("FAIL inject_err: got %h want %h", err_cnt, want); end
    endtask
`endif

    task automatic test_rx_zero();
        int s0 [NL];
        int cyc;
        for (int l = 0; l < NL; l++) s0[l] = slips[l];
        rx_mode = 1;
        pulse_start();
        cyc = 0;
        while (lane_fail !== 4'hF && cyc < 400) begin @(negedge clk); cyc++; end
        n_checks++; if (lane_fail !== 4'hF) begin n_errors++; $display("FAIL zero_fail: got %b want 1111", lane_fail); end
        for (int l = 0; l < NL; l++) begin
            n_checks++; if (slips[l] - s0[l] !== 8) begin n_errors++; $display("FAIL zero_slips lane %0d: got %0d want 8", l, slips[l] - s0[l]); end
        end
        wait_cycles(20);
        n_checks++; if (lane_fail !== 4'hF) begin n_errors++; $display("FAIL zero_fail_hold: got %b want 1111", lane_fail); end
        n_checks++; if (lane_locked !== 4'h0) begin n_errors++; $display("FAIL zero_locked: got %b want 0", lane_locked); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        n_checks++; if (sif.tx_data[W-1:0] !== 8'h17) begin n_errors++; $display("FAIL zero_tx: got %h want 17", sif.tx_data[W-1:0]); end
    endtask

    initial begin
        test_reset();
        test_lock_lane0();
        test_rx_flip();
        test_saturate();
        test_reset_mid_check();
        test_multi_lane();
`ifdef SERDES_LANE_CHECKER_INJECT_EN
        test_inject();
`endif
        test_rx_zero();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serdes_lane_checker.md
Name: serdes_lane_checker

Overview:
Parametrised multi-lane successor to the single-lane SERDES loopback test. It runs in the CLKDIV domain between the user-side parallel ports of OSERDES/ISERDES pairs. Per lane, it transmits a training word, aligns the receive word boundary by pulsing BITSLIP, then switches to PRBS-7 traffic and counts bit errors with a self-synchronising checker.

Parameters:
NUM_LANES, 1, number of independent lanes (1..16).
DATA_WIDTH, 8, parallel word width per lane (2..8).
TRAIN_WORD, 8'h17, training word; low DATA_WIDTH bits are used and all their rotations must be distinct.
MATCH_COUNT, 16, consecutive matching words required to declare lock.
SLIP_WAIT, 4, cycles rx is ignored after TRAIN entry and after each bitslip.
ERR_CNT_WIDTH, 16, width of each lane's error counter.

Ports:
clk  input  1  parallel-word clock (CLKDIV domain).
rst  input  1  asynchronous reset, active-high.
start  input  1  single-cycle pulse; restarts all lanes.
tx_data  output  NUM_LANES*DATA_WIDTH  to OSERDES D inputs; lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]; bit 0 is serialised first.
rx_data  input  NUM_LANES*DATA_WIDTH  from ISERDES Q outputs; same packing.
bitslip  output  NUM_LANES  one-cycle BITSLIP pulse per lane.
lane_locked  output  NUM_LANES  lane is in CHECK.
lane_fail  output  NUM_LANES  alignment failed.
err_cnt  output  NUM_LANES*ERR_CNT_WIDTH  per-lane saturating bit-error count.
busy  output  1  OR of all lanes in TRAIN/SLIP/WAIT.

Behaviour:
- Reset (async, asserted): every output is 0; all lanes are in IDLE; PRBS state is 7'h7F. rst takes priority over start.
- Per-lane FSM states: IDLE, WAIT, TRAIN, SLIP, CHECK, FAIL.
- start in any state: clear err_cnt, slip count, match count, locked and fail; reseed PRBS; go to WAIT; tx_data = TRAIN_WORD.
- WAIT: ignore rx for SLIP_WAIT cycles, then go to TRAIN.
- TRAIN: tx_data = TRAIN_WORD.
  - rx word == TRAIN_WORD: increment match count. On reaching MATCH_COUNT, go to CHECK.
  - Mismatch with slip count < DATA_WIDTH: clear match count and go to SLIP.
  - Mismatch with slip count == DATA_WIDTH: go to FAIL.
- SLIP: assert bitslip for exactly 1 cycle, increment slip count, go to WAIT.
- FAIL: lane_fail = 1 and tx_data = TRAIN_WORD. Only start or rst leaves this state.
- CHECK: lane_locked = 1. tx_data carries the PRBS-7 bit stream s[n] = s[n-7] ^ s[n-6].
  - Word k holds s[kW+i] in bit i, with W = DATA_WIDTH.
  - W bits advance per cycle; first CHECK word is generated from seed 7'h7F.
- Checker: self-synchronising. The predicted bit is rx[n-7] ^ rx[n-6], taken from the received history, including bits carried across the previous word.
  - mismatch bits = popcount of the per-bit XOR between predicted and received bits.
  - The first ceil(7/DATA_WIDTH) words after CHECK entry are not counted.
- err_cnt: adds the per-word popcount each cycle and saturates at all-ones (no wrap).
- Mismatches in CHECK never drop lock.
- Lanes are fully independent; busy is the combinational OR of per-lane training states.
- Latency: start -> first TRAIN_WORD on tx_data is 1 cycle. rx sample -> err_cnt update is 1 cycle.

Optional Feature:
Macro SERDES_LANE_CHECKER_INJECT_EN.
- Defined: adds input inject_err (1 bit). A one-cycle pulse while lane 0 is in CHECK inverts tx_data bit 0 of lane 0 for the next word only. Through the self-synchronising checker this yields exactly 3 counted errors. The pulse is ignored outside CHECK.
- Undefined: no port and no logic; tx_data is unaltered.

Test Plan:
1. NUM_LANES=1, loopback model with rx = tx delayed 2 cycles and a rotation requiring 3 slips; pulse start -> exactly 3 bitslip pulses, lane_locked=1, lane_fail=0, err_cnt stays 0 over 1000 CHECK cycles.
2. rx_data tied to 0 after start -> 8 bitslip pulses, then lane_fail=1, lane_locked=0, busy=0.
3. Locked lane; flip one rx bit in one word -> err_cnt increases by exactly 3, and lock is held.
4. ERR_CNT_WIDTH=8; in CHECK, force rx to alternating 8'h55/8'hAA for 200 words -> err_cnt saturates at 255 and stays there.
5. Assert rst mid-CHECK -> all outputs 0 in the same cycle; on deassert, start relocks within the bound of test 1.
6. NUM_LANES=4 with per-lane rotations requiring 0/1/2/3 slips -> slip pulse counts 0/1/2/3, all four lanes locked, no cross-lane interaction.
7. With SERDES_LANE_CHECKER_INJECT_EN defined, pulse inject_err in CHECK -> err_cnt[lane 0] increments by exactly 3.
